trig_cond: RTL and testbench
============================

Name: trig_cond

Overview:
- Parametrised N-channel trigger input conditioner in the fe_clk domain.
- Generalises the single registered target-trigger path into a configurable block. Per channel it provides synchroniser, polarity, glitch filter and edge select. Channels are combined by OR/AND, followed by a pulse stretcher with holdoff and a saturating trigger counter.
- Output drives the trace trigger / MCX trigger path; configuration comes from trace register space.

Parameters:
- pCHANNELS, 4, number of trigger inputs (1..16)
- pFILTER_WIDTH, 4, width of per-channel glitch-filter length
- pSTRETCH_WIDTH, 16, width of stretch and holdoff lengths
- pCOUNT_WIDTH, 16, width of trigger event counter

Ports:
- fe_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- I_trig_in  in  pCHANNELS  raw asynchronous trigger inputs
- I_chan_en  in  pCHANNELS  per-channel enable
- I_invert  in  pCHANNELS  per-channel polarity invert (applied before filter)
- I_edge_sel  in  2*pCHANNELS  per channel: 00 rising, 01 falling, 10 both, 11 level-high
- I_filter_len  in  pFILTER_WIDTH  required stable cycles before filtered level changes
- I_and_mode  in  1  0: OR of channel events; 1: AND of enabled channel qualifiers
- I_stretch_len  in  pSTRETCH_WIDTH  output high time minus 1
- I_holdoff  in  pSTRETCH_WIDTH  cycles after pulse end during which events are ignored
- I_retrigger  in  1  1: event during pulse reloads stretch counter
- I_arm  in  1  events accepted only while high
- I_count_clear  in  1  synchronous clear of O_trig_count
- O_trig  out  1  conditioned trigger output (registered)
- O_trig_count  out  pCOUNT_WIDTH  accepted-event count, saturating
- O_busy  out  1  high in PULSE or HOLDOFF
- O_filt_level  out  pCHANNELS  filtered per-channel levels (post-invert)

Behaviour:
- Reset (reset_n low, async):
  - O_trig=0, O_trig_count=0, O_busy=0, O_filt_level=0.
  - Synchronisers, filter counters and FSM all cleared; FSM in IDLE.
- Synchroniser: two flops per channel, then XOR with I_invert.
- Filter:
  - Per-channel counter. When the synced value differs from the filtered value, count up; reset to 0 when they match.
  - The filtered value takes the synced value when count == I_filter_len. I_filter_len=0 updates on the next edge.
- Qualifier per channel (combinational, from filt and filt_d):
  - rising: filt & ~filt_d
  - falling: ~filt & filt_d
  - both: filt ^ filt_d
  - level: filt
  - Disabled channels contribute 0 in OR mode and 1 in AND mode.
- Combine:
  - OR mode: event = OR of qualifiers.
  - AND mode: event = rising edge of (AND of qualifiers), so a sustained AND yields one event.
  - No channel enabled: never an event.
- Latency: with filter_len=0, O_trig rises on the 4th fe_clk edge counting the first edge that samples the new input. Each unit of I_filter_len adds 1 cycle.
- FSM:
  - IDLE: event & I_arm -> PULSE; O_trig<=1; load stretch counter with I_stretch_len; count++.
  - PULSE, counter>0: decrement.
  - PULSE, event & I_arm & I_retrigger: reload counter; count++.
  - PULSE, event with I_retrigger=0: ignored.
  - PULSE, counter==0 and no reload: O_trig<=0. Go to HOLDOFF if I_holdoff!=0, else IDLE.
  - HOLDOFF: counter loaded with I_holdoff-1 and decremented; events ignored; counter==0 -> IDLE. Holdoff lasts exactly I_holdoff cycles.
- Pulse length: exactly I_stretch_len+1 cycles without retrigger.
- Config sampling: I_stretch_len and I_holdoff are sampled only at load; changes mid-pulse take effect on the next load.
- Disarm: I_arm falling mid-pulse lets the pulse and holdoff complete normally.
- Counter: saturates at all-ones. I_count_clear takes priority over a simultaneous increment (result 0).
- O_busy = (state != IDLE), registered alongside state.

Test Plan:
- Ch0 rising, filter_len=0, stretch=3, holdoff=0; ch0 0->1 -> O_trig high on 4th edge for exactly 4 cycles; count=1.
- filter_len=5; 4-cycle glitch on ch1 -> no O_trig, O_filt_level[1] stays 0; 6-cycle high -> O_trig rises 5 cycles later than in the filter_len=0 case.
- AND mode, ch0 and ch1 level; ch0 high, then ch1 high 10 cycles later -> one event 4 cycles after ch1 edge; holding both high produces no further events.
- stretch=9, retrigger=1, second event 5 cycles into pulse -> O_trig high 15 cycles, count=2; retrigger=0 -> 10 cycles, count=1.
- holdoff=8, events every 3 cycles, stretch=0 -> O_trig pulses exactly every 10 cycles; O_busy high throughout.
- Count preset near saturation with 16-bit width: events drive count to 0xFFFF and it stays there; clear with simultaneous event -> 0. Assert reset_n mid-pulse -> O_trig=0 immediately.

Source files
------------

// File: rtl/trig_cond.sv
// Trigger input conditioner: per-channel synchroniser, polarity, glitch filter and
// edge select, OR/AND combine, then pulse stretcher with holdoff and event counter.
module trig_cond #(
    parameter int pCHANNELS     = 4,
    parameter int pFILTER_WIDTH = 4,
    parameter int pSTRETCH_WIDTH = 16,
    parameter int pCOUNT_WIDTH  = 16
) (
    input  logic                       fe_clk,
    input  logic                       reset_n,
    input  logic [pCHANNELS-1:0]       I_trig_in,
    input  logic [pCHANNELS-1:0]       I_chan_en,
    input  logic [pCHANNELS-1:0]       I_invert,
    input  logic [2*pCHANNELS-1:0]     I_edge_sel,
    input  logic [pFILTER_WIDTH-1:0]   I_filter_len,
    input  logic                       I_and_mode,
    input  logic [pSTRETCH_WIDTH-1:0]  I_stretch_len,
    input  logic [pSTRETCH_WIDTH-1:0]  I_holdoff,
    input  logic                       I_retrigger,
    input  logic                       I_arm,
    input  logic                       I_count_clear,
    output logic                       O_trig,
    output logic [pCOUNT_WIDTH-1:0]    O_trig_count,
    output logic                       O_busy,
    output logic [pCHANNELS-1:0]       O_filt_level
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLDOFF
    } state_t;

    logic [pCHANNELS-1:0]      sync_meta;
    logic [pCHANNELS-1:0]      sync_q;
    logic [pCHANNELS-1:0]      synced;
    logic [pCHANNELS-1:0]      filt;
    logic [pCHANNELS-1:0]      filt_d;
    logic [pFILTER_WIDTH-1:0]  filt_cnt [pCHANNELS];

    logic [pCHANNELS-1:0]      qual;
    logic [pCHANNELS-1:0]      or_qual;
    logic [pCHANNELS-1:0]      and_qual;
    logic                      any_en;
    logic                      and_all;
    logic                      and_all_d;
    logic                      trig_event;
    logic                      fire;
    logic                      count_inc;

    state_t                    state;
    logic [pSTRETCH_WIDTH-1:0] stretch_cnt;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= I_trig_in;
            sync_q    <= sync_meta;
        end
    end

    assign synced = sync_q ^ I_invert;

    // The filtered level only follows the synced level after it has disagreed
    // for I_filter_len+1 consecutive samples; any agreement restarts the count.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < pCHANNELS; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            filt_d <= filt;
            for (int i = 0; i < pCHANNELS; i++) begin
                if (synced[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == I_filter_len) begin
                    filt[i]     <= synced[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign O_filt_level = filt;

    always_comb begin
        qual     = '0;
        or_qual  = '0;
        and_qual = '1;
        for (int i = 0; i < pCHANNELS; i++) begin
            case (I_edge_sel[2*i +: 2])
                2'b00:   qual[i] = filt[i] & ~filt_d[i];
                2'b01:   qual[i] = ~filt[i] & filt_d[i];
                2'b10:   qual[i] = filt[i] ^ filt_d[i];
                default: qual[i] = filt[i];
            endcase
            or_qual[i]  = I_chan_en[i] & qual[i];
            and_qual[i] = ~I_chan_en[i] | qual[i];
        end
    end

    // Disabled channels read as 1 in AND mode, so an all-disabled set must be
    // gated explicitly or it would look like a permanently satisfied AND.
    assign any_en  = |I_chan_en;
    assign and_all = any_en & (&and_qual);

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            and_all_d <= 1'b0;
        end else begin
            and_all_d <= and_all;
        end
    end

    assign trig_event = I_and_mode ? (and_all & ~and_all_d) : (|or_qual);
    assign fire       = trig_event & I_arm;
    assign count_inc  = fire & ((state == ST_IDLE) | ((state == ST_PULSE) & I_retrigger));

    // One counter serves both the stretch and the holdoff phase; the lengths
    // are sampled only when the counter is loaded.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            stretch_cnt <= '0;
            O_trig      <= 1'b0;
            O_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state       <= ST_PULSE;
                        stretch_cnt <= I_stretch_len;
                        O_trig      <= 1'b1;
                        O_busy      <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (fire && I_retrigger) begin
                        stretch_cnt <= I_stretch_len;
                    end else if (stretch_cnt != '0) begin
                        stretch_cnt <= stretch_cnt - 1'b1;
                    end else begin
                        O_trig <= 1'b0;
                        if (I_holdoff != '0) begin
                            state       <= ST_HOLDOFF;
                            stretch_cnt <= I_holdoff - 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            O_busy <= 1'b0;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (stretch_cnt == '0) begin
                        state  <= ST_IDLE;
                        O_busy <= 1'b0;
                    end else begin
                        stretch_cnt <= stretch_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    O_trig <= 1'b0;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_trig_count <= '0;
        end else if (I_count_clear) begin
            O_trig_count <= '0;
        end else if (count_inc && (O_trig_count != {pCOUNT_WIDTH{1'b1}})) begin
            O_trig_count <= O_trig_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_trig_cond.sv
// Directed bench for trig_cond; a second instance with a 4-bit counter exercises
// saturation without running tens of thousands of events.
module tb_trig_cond;

    logic        fe_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  trig_in;
    logic [3:0]  chan_en;
    logic [3:0]  invert;
    logic [7:0]  edge_sel;
    logic [3:0]  filter_len;
    logic        and_mode;
    logic [15:0] stretch_len;
    logic [15:0] holdoff;
    logic        retrigger;
    logic        arm;
    logic        count_clear;

    logic        trig;
    logic [15:0] trig_count;
    logic        busy;
    logic [3:0]  filt_level;
    logic        sat_trig;
    logic [3:0]  sat_count;
    logic        sat_busy;
    logic [3:0]  sat_filt;

    int passed = 0;
    int total  = 0;

    always #5 fe_clk = ~fe_clk;

    trig_cond dut (
        .fe_clk(fe_clk), .reset_n(reset_n), .I_trig_in(trig_in), .I_chan_en(chan_en),
        .I_invert(invert), .I_edge_sel(edge_sel), .I_filter_len(filter_len),
        .I_and_mode(and_mode), .I_stretch_len(stretch_len), .I_holdoff(holdoff),
        .I_retrigger(retrigger), .I_arm(arm), .I_count_clear(count_clear),
        .O_trig(trig), .O_trig_count(trig_count), .O_busy(busy), .O_filt_level(filt_level)
    );

    trig_cond #(.pCOUNT_WIDTH(4)) u_sat (
        .fe_clk(fe_clk), .reset_n(reset_n), .I_trig_in(trig_in), .I_chan_en(chan_en),
        .I_invert(invert), .I_edge_sel(edge_sel), .I_filter_len(filter_len),
        .I_and_mode(and_mode), .I_stretch_len(stretch_len), .I_holdoff(holdoff),
        .I_retrigger(retrigger), .I_arm(arm), .I_count_clear(count_clear),
        .O_trig(sat_trig), .O_trig_count(sat_count), .O_busy(sat_busy), .O_filt_level(sat_filt)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fe_clk);
            #1;
        end
    endtask

    task automatic set_defaults();
        trig_in     = 4'b0000;
        chan_en     = 4'b0001;
        invert      = 4'b0000;
        edge_sel    = 8'h00;
        filter_len  = 4'd0;
        and_mode    = 1'b0;
        stretch_len = 16'd3;
        holdoff     = 16'd0;
        retrigger   = 1'b0;
        arm         = 1'b1;
        count_clear = 1'b0;
    endtask

    task automatic do_reset();
        trig_in = 4'b0000;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        set_defaults();
        reset_n = 1'b1;
        trig_in = 4'b1111;
        invert  = 4'b0000;
        tick(4);
        reset_n = 1'b0;
        #2;
        total++; if (trig !== 1'b0) $display("FAIL reset_trig: got %0b expected 0", trig); else passed++;
        total++; if (trig_count !== 16'd0) $display("FAIL reset_count: got %0h expected 0", trig_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
        total++; if (filt_level !== 4'b0000) $display("FAIL reset_filt: got %0b expected 0000", filt_level); else passed++;
        tick(2);
    endtask

    task automatic test_latency();
        int rise;
        int high_len;
        set_defaults();
        do_reset();
        rise = -1;
        high_len = 0;
        trig_in[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (trig === 1'b1 && rise < 0) rise = t;
            if (trig === 1'b1) high_len++;
        end
        total++; if (rise != 4) $display("FAIL latency_rise: got edge %0d expected 4", rise); else passed++;
        total++; if (high_len != 4) $display("FAIL latency_len: got %0d expected 4", high_len); else passed++;
        total++; if (trig_count !== 16'd1) $display("FAIL latency_count: got %0d expected 1", trig_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL latency_busy_end: got %0b expected 0", busy); else passed++;
        invert = 4'b0100;
        tick(3);
        total++; if (filt_level !== 4'b0101) $display("FAIL invert_filt: got %0b expected 0101", filt_level); else passed++;
        invert = 4'b0000;
        tick(3);
    endtask

    task automatic test_filter();
        int rise;
        logic glitch_trig;
        logic glitch_filt;
        set_defaults();
        filter_len = 4'd5;
        chan_en    = 4'b0010;
        do_reset();
        glitch_trig = 1'b0;
        glitch_filt = 1'b0;
        trig_in[1] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (t == 4) trig_in[1] = 1'b0;
            if (trig === 1'b1) glitch_trig = 1'b1;
            if (filt_level[1] === 1'b1) glitch_filt = 1'b1;
        end
        total++; if (glitch_trig !== 1'b0) $display("FAIL glitch_trig: got %0b expected 0", glitch_trig); else passed++;
        total++; if (glitch_filt !== 1'b0) $display("FAIL glitch_filt: got %0b expected 0", glitch_filt); else passed++;
        rise = -1;
        trig_in[1] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (t == 6) trig_in[1] = 1'b0;
            if (trig === 1'b1 && rise < 0) rise = t;
        end
        total++; if (rise != 9) $display("FAIL filter_rise: got edge %0d expected 9", rise); else passed++;
        total++; if (filt_level[1] !== 1'b0) $display("FAIL filter_fall: got %0b expected 0", filt_level[1]); else passed++;
    endtask

    task automatic test_and_mode();
        int rise;
        int pulses;
        logic early;
        logic prev;
        set_defaults();
        and_mode = 1'b1;
        chan_en  = 4'b0011;
        edge_sel = 8'h0F;
        do_reset();
        early = 1'b0;
        trig_in[0] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            if (trig === 1'b1) early = 1'b1;
        end
        total++; if (early !== 1'b0) $display("FAIL and_single: got %0b expected 0", early); else passed++;
        rise = -1;
        pulses = 0;
        prev = 1'b0;
        trig_in[1] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (trig === 1'b1 && prev === 1'b0) pulses++;
            if (trig === 1'b1 && rise < 0) rise = t;
            prev = trig;
        end
        total++; if (rise != 4) $display("FAIL and_rise: got edge %0d expected 4", rise); else passed++;
        total++; if (pulses != 1) $display("FAIL and_pulses: got %0d expected 1", pulses); else passed++;
        total++; if (trig_count !== 16'd1) $display("FAIL and_count: got %0d expected 1", trig_count); else passed++;
    endtask

    task automatic test_no_channel();
        logic seen;
        set_defaults();
        and_mode = 1'b1;
        chan_en  = 4'b0000;
        edge_sel = 8'hFF;
        do_reset();
        seen = 1'b0;
        trig_in = 4'b1111;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (trig === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL nochan_trig: got %0b expected 0", seen); else passed++;
        total++; if (trig_count !== 16'd0) $display("FAIL nochan_count: got %0d expected 0", trig_count); else passed++;
    endtask

    task automatic test_retrigger();
        int high_len;
        int exp_len;
        int exp_cnt;
        for (int r = 0; r < 2; r++) begin
            set_defaults();
            stretch_len = 16'd9;
            retrigger   = r[0];
            exp_len     = (r == 1) ? 15 : 10;
            exp_cnt     = (r == 1) ? 2 : 1;
            do_reset();
            high_len = 0;
            trig_in[0] = 1'b1;
            for (int t = 1; t <= 40; t++) begin
                tick(1);
                if (t == 2) trig_in[0] = 1'b0;
                if (t == 5) trig_in[0] = 1'b1;
                if (trig === 1'b1) high_len++;
            end
            total++; if (high_len != exp_len) $display("FAIL retrig%0d_len: got %0d expected %0d", r, high_len, exp_len); else passed++;
            total++; if (trig_count !== 16'(exp_cnt)) $display("FAIL retrig%0d_count: got %0d expected %0d", r, trig_count, exp_cnt); else passed++;
        end
    endtask

    task automatic test_disarm();
        int high_len;
        logic seen;
        set_defaults();
        stretch_len = 16'd9;
        arm = 1'b0;
        do_reset();
        seen = 1'b0;
        trig_in[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (trig === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL disarmed_trig: got %0b expected 0", seen); else passed++;
        arm = 1'b1;
        do_reset();
        high_len = 0;
        trig_in[0] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (t == 5) arm = 1'b0;
            if (trig === 1'b1) high_len++;
        end
        total++; if (high_len != 10) $display("FAIL disarm_len: got %0d expected 10", high_len); else passed++;
        total++; if (trig_count !== 16'd1) $display("FAIL disarm_count: got %0d expected 1", trig_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL disarm_busy: got %0b expected 0", busy); else passed++;
    endtask

    task automatic test_holdoff();
        int rises [4];
        int nrise;
        int busy_hi;
        int high_len;
        set_defaults();
        edge_sel    = 8'h03;
        stretch_len = 16'd0;
        holdoff     = 16'd8;
        do_reset();
        nrise = 0;
        busy_hi = 0;
        high_len = 0;
        for (int i = 0; i < 4; i++) rises[i] = -100;
        trig_in[0] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            if (trig === 1'b1) begin
                high_len++;
                if (nrise < 4) rises[nrise] = t;
                nrise++;
            end
            if (t >= 4 && t <= 12 && busy === 1'b1) busy_hi++;
        end
        total++; if (rises[0] != 4) $display("FAIL holdoff_first: got edge %0d expected 4", rises[0]); else passed++;
        total++; if (rises[1] - rises[0] != 10) $display("FAIL holdoff_period1: got %0d expected 10", rises[1] - rises[0]); else passed++;
        total++; if (rises[2] - rises[1] != 10) $display("FAIL holdoff_period2: got %0d expected 10", rises[2] - rises[1]); else passed++;
        total++; if (high_len != 4) $display("FAIL holdoff_high: got %0d expected 4", high_len); else passed++;
        total++; if (busy_hi != 9) $display("FAIL holdoff_busy: got %0d expected 9", busy_hi); else passed++;
    endtask

    task automatic test_saturation();
        set_defaults();
        edge_sel    = 8'h03;
        stretch_len = 16'd0;
        retrigger   = 1'b1;
        do_reset();
        trig_in[0] = 1'b1;
        tick(25);
        total++; if (sat_count !== 4'hF) $display("FAIL sat_count: got %0h expected f", sat_count); else passed++;
        total++; if (trig_count !== 16'd22) $display("FAIL sat_wide_count: got %0d expected 22", trig_count); else passed++;
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        total++; if (sat_count !== 4'h0) $display("FAIL clear_sat: got %0h expected 0", sat_count); else passed++;
        total++; if (trig_count !== 16'd0) $display("FAIL clear_wide: got %0d expected 0", trig_count); else passed++;
        tick(1);
        total++; if (trig_count !== 16'd1) $display("FAIL after_clear: got %0d expected 1", trig_count); else passed++;
    endtask

    task automatic test_reset_mid_pulse();
        set_defaults();
        stretch_len = 16'd9;
        do_reset();
        trig_in[0] = 1'b1;
        tick(6);
        total++; if (trig !== 1'b1) $display("FAIL midpulse_high: got %0b expected 1", trig); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (trig !== 1'b0) $display("FAIL midpulse_trig: got %0b expected 0", trig); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midpulse_busy: got %0b expected 0", busy); else passed++;
        total++; if (trig_count !== 16'd0) $display("FAIL midpulse_count: got %0d expected 0", trig_count); else passed++;
        tick(1);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        reset_n = 1'b0;
        set_defaults();
        test_reset();
        test_latency();
        test_filter();
        test_and_mode();
        test_no_channel();
        test_retrigger();
        test_disarm();
        test_holdoff();
        test_saturation();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
